// File: rtl/mem_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_sched
// Description : Round-robin share of one memory request/response port among
//               NUM_REQS requesters, with per-requester read limits and a
//               flush/drain handshake. Define MEM_SCHED_PERF_EN to add
//               per-requester stall counters (perf_stall_cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_sched #(
    parameter int NUM_REQS     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 512,
    parameter int TAG_IN_WIDTH = 8,
    parameter int MAX_PENDING  = 8,
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + $clog2(NUM_REQS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid_in,
    input  logic [NUM_REQS-1:0]              req_rw_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
    output logic [NUM_REQS-1:0]              req_ready_in,
    output logic                             req_valid_out,
    output logic                             req_rw_out,
    output logic [ADDR_WIDTH-1:0]            req_addr_out,
    output logic [DATA_WIDTH-1:0]            req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
    input  logic                             req_ready_out,
    input  logic                             rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]            rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
    output logic                             rsp_ready_in,
    output logic [NUM_REQS-1:0]              rsp_valid_out,
    output logic [DATA_WIDTH-1:0]            rsp_data_out,
    output logic [TAG_IN_WIDTH-1:0]          rsp_tag_out,
    input  logic [NUM_REQS-1:0]              rsp_ready_out,
    input  logic                             flush_req,
    output logic                             flush_done,
    output logic                             busy
`ifdef MEM_SCHED_PERF_EN
    ,
    output logic [NUM_REQS*32-1:0]           perf_stall_cycles
`endif
);

    localparam int c_idx_w  = $clog2(NUM_REQS);
    localparam int c_pend_w = $clog2(MAX_PENDING + 1);
    localparam logic [c_pend_w-1:0] c_max_pend = c_pend_w'(MAX_PENDING);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;
    localparam logic [1:0] c_st_idle  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    w_run;
    logic [c_idx_w-1:0]      r_ptr;
    logic [c_idx_w-1:0]      w_gnt_idx;
    logic                    w_any_elig;
    logic                    w_grant;
    logic [NUM_REQS-1:0]     w_elig;
    logic [NUM_REQS-1:0]     w_inc;
    logic [NUM_REQS-1:0]     w_dec;
    logic [NUM_REQS-1:0]     w_pend_nz;
    logic [c_pend_w-1:0]     r_pend [NUM_REQS];

    logic                    r_rsp_valid;
    logic [c_idx_w-1:0]      r_rsp_idx;
    logic                    w_rsp_sel_ready;

    // Per-requester eligibility and outstanding-read bookkeeping
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
        assign w_elig[i]    = req_valid_in[i] && w_run && (req_rw_in[i] || (r_pend[i] != c_max_pend));
        assign w_inc[i]     = req_ready_in[i] && !req_rw_in[i];
        assign w_dec[i]     = rsp_valid_out[i] && rsp_ready_out[i];
        assign w_pend_nz[i] = |r_pend[i];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pend[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_pend[i] <= r_pend[i] + 1'b1;
            end else if (!w_inc[i] && w_dec[i] && w_pend_nz[i]) begin
                r_pend[i] <= r_pend[i] - 1'b1;
            end
        end

`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (reset) begin
                assert (!(w_dec[i] && !w_inc[i] && !w_pend_nz[i]))
                    else $error("pend underflow on requester %0d", i);
            end
        end
`endif
    end

    // Search starts one past the last winner so every requester gets a turn
    always_comb begin
        w_any_elig = 1'b0;
        w_gnt_idx  = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            if (!w_any_elig && w_elig[(int'(r_ptr) + k) % NUM_REQS]) begin
                w_any_elig = 1'b1;
                w_gnt_idx  = c_idx_w'((int'(r_ptr) + k) % NUM_REQS);
            end
        end
        w_grant      = w_any_elig && (!req_valid_out || req_ready_out);
        req_ready_in = w_grant ? (NUM_REQS'(1) << w_gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr         <= '0;
            req_valid_out <= 1'b0;
            req_rw_out    <= 1'b0;
            req_addr_out  <= '0;
            req_data_out  <= '0;
            req_tag_out   <= '0;
        end else if (w_grant) begin
            r_ptr         <= w_gnt_idx;
            req_valid_out <= 1'b1;
            req_rw_out    <= req_rw_in[w_gnt_idx];
            req_addr_out  <= req_addr_in[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            req_data_out  <= req_data_in[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            req_tag_out   <= {req_tag_in[int'(w_gnt_idx)*TAG_IN_WIDTH +: TAG_IN_WIDTH], w_gnt_idx};
        end else if (req_ready_out) begin
            req_valid_out <= 1'b0;
        end
    end

    // Response buffer: requester index lives in the tag LSBs
    assign w_rsp_sel_ready = rsp_ready_out[r_rsp_idx];
    assign rsp_ready_in    = !r_rsp_valid || w_rsp_sel_ready;
    assign rsp_valid_out   = r_rsp_valid ? (NUM_REQS'(1) << r_rsp_idx) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_idx    <= '0;
            rsp_data_out <= '0;
            rsp_tag_out  <= '0;
        end else if (rsp_valid_in && rsp_ready_in) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_idx    <= rsp_tag_in[c_idx_w-1:0];
            rsp_data_out <= rsp_data_in;
            rsp_tag_out  <= rsp_tag_in[TAG_OUT_WIDTH-1:c_idx_w];
        end else if (w_rsp_sel_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run:   if (flush_req) w_state_nxt = c_st_drain;
            c_st_drain: if (!(|w_pend_nz) && !req_valid_out) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            c_st_idle:  if (!flush_req) w_state_nxt = c_st_run;
            default:    w_state_nxt = c_st_run;
        endcase
    end

    always_comb begin
        w_run      = (r_state == c_st_run);
        flush_done = (r_state == c_st_done);
    end

    assign busy = (|w_pend_nz) | req_valid_out | r_rsp_valid;

`ifdef MEM_SCHED_PERF_EN
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_perf
        logic [31:0] r_stall;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_stall <= '0;
            end else if (req_valid_in[i] && !req_ready_in[i]) begin
                r_stall <= r_stall + 32'd1;
            end
        end
        assign perf_stall_cycles[i*32 +: 32] = r_stall;
    end
`endif

endmodule
`default_nettype wire
